bch_t12_parity_fold_engine: RTL
===============================

// Module: bch_t12_parity_fold_engine
// PURPOSE
//  DVB-S2 BCH (normal frame, t=12) parity engine. It reads the 24-row "next" fold ROM through its rd_en/rdaddr/rd_q port
//  and folds 24-bit data words into a 192-bit remainder. It sits between the BB-frame scrambler and the LDPC encoder.
//  At end of frame it emits the 192 parity bits as eight 24-bit words, MSB first.
//  ROM row j (addr 5'h00..5'h17) = x^(192+j) mod g(x), held as a 192-bit vector.
// PARAMETERS
//  PAR_W    192  remainder / parity width (= ROM row width)
//  WORD_W   24   data word width (= number of ROM rows read per fold)
//  ADDR_W   5    ROM address width
//  OUT_WRDS 8    parity words per frame (PAR_W/WORD_W)
// PORTS
//  clk_1x      in   1    clock
//  rst_n       in   1    synchronous, active-low reset
//  in_valid    in   1    data word valid
//  in_ready    out  1    engine can accept a word
//  in_data     in   24   data; bit 23 is oldest in time
//  in_sof      in   1    first word of frame (qualified by in_valid&in_ready)
//  in_eof      in   1    last word of frame
//  out_valid   out  1    parity word valid
//  out_ready   in   1    downstream accepts parity word
//  out_data    out  24   parity word, remainder bits 191..168 first
//  out_last    out  1    asserted with the 8th parity word
//  rom_rd_en   out  1    ROM read enable
//  rom_rdaddr  out  5    ROM row address
//  rom_rd_q    in   192  ROM data; valid 1 cycle after rom_rd_en
//  busy        out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE. r, acc, f, cnt=0. in_ready=1. out_valid=0, out_data=0, out_last=0, rom_rd_en=0, rom_rdaddr=0, busy=0.
//  States: IDLE -> FOLD -> DRAIN -> (IDLE | OUT); OUT -> IDLE after 8th word accepted.
//  IDLE: in_ready=1. On accept (cycle 0): rb = in_sof ? 0 : r; f <= rb[191:168]^in_data; keep rb; acc<=0; eof flag<=in_eof.
//  FOLD: cycles 1..24: rom_rd_en=1, rom_rdaddr=0..23 (ascending); in_ready=0.
//  Accumulate: in cycles 2..25, acc ^= f[j] ? rom_rd_q : 0, with j = address issued the previous cycle.
//  DRAIN (cycle 25): captures row 23. It commits r <= {rb[167:0],24'b0} ^ acc_final.
//    Next state: OUT if eof flag set, else IDLE. in_ready=1 again at cycle 26 (26-cycle occupancy per word).
//  OUT: out_valid=1; out_data=r[191:168]. On out_valid&out_ready: r <= r<<24, cnt++.
//    out_last=1 when cnt==7. After the 8th accept: r=0, go to IDLE.
//    out_data/out_last are held stable while out_ready=0. in_ready=0 throughout OUT.
//  in_sof&in_eof on one word is a legal 1-word frame. in_sof mid-frame discards the old remainder (restart).
//  in_valid=0 in IDLE: remain idle, no ROM reads. rom_rdaddr never exceeds 5'h17. rom_rd_en=0 outside FOLD.
//  All arithmetic is GF(2) XOR, 192-bit wide, no carries. Reset in any state aborts immediately to reset values.
// CONFIGURATION
//  BCH_ZERO_SKIP_EN defined: on accept with f==24'h0, skip FOLD/DRAIN. r <= {rb[167:0],24'b0} at cycle 1.
//    Next state is OUT if eof, else IDLE with in_ready=1 at cycle 1. No ROM reads are issued.
//  BCH_ZERO_SKIP_EN undefined: every word takes the full 26-cycle FOLD/DRAIN path (24 ROM reads), even when f==0.
//  Parity results are identical in both builds; only timing and ROM activity differ.
// TESTING
//  1. 4-word frame, all data 24'h0 -> eight out words 24'h000000, out_last on 8th. Macro off: 24 reads per word.
//  2. 1-word frame in_data=24'h800000, sof+eof -> parity == ROM row 5'h17, emitted MSB first as 8 words.
//  3. 1-word frame in_data=24'h000001 -> parity == ROM row 5'h00 (24'hC20DB5 first, 24'h...EE7B last).
//  4. 100 random words, random in_valid gaps, out_ready toggling -> parity matches bit-serial g(x) LFSR model.
//     out_data is stable under stall. in_ready is low for exactly cycles 1..25 after each accept.
//  5. rst_n=0 at FOLD cycle 10, then new 1-word frame 24'h800000 -> all outputs at reset values; parity == row 5'h17.
//  6. BCH_ZERO_SKIP_EN defined, frame {24'h0,24'h0,24'h800000(eof)} -> zero words accepted back-to-back (1 cycle each).
//     Parity is identical to the macro-off result.

Source files
------------

// File: rtl/bch_t12_parity_fold_engine.sv
// DVB-S2 normal-frame BCH (t=12) parity engine: folds 24-bit words into a 192-bit remainder via a 24-row ROM.
// Optional build macro BCH_ZERO_SKIP_EN: words whose fold vector is zero bypass the ROM walk.
module bch_t12_parity_fold_engine #(
    parameter int PAR_W    = 192,
    parameter int WORD_W   = 24,
    parameter int ADDR_W   = 5,
    parameter int OUT_WRDS = 8
) (
    input  logic              clk_1x,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_rdaddr,
    input  logic [PAR_W-1:0]  rom_rd_q,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(OUT_WRDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(OUT_WRDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FOLD,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [PAR_W-1:0]  r;
    logic [PAR_W-1:0]  acc;
    logic [PAR_W-1:0]  acc_fin;
    logic [PAR_W-1:0]  rb;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] f_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_p1;
    logic              vld_p1;
    logic              eof_flag;
    logic              accept;
    logic              out_fire;
    logic              zero_skip;

    function automatic logic [PAR_W-1:0] fold_term(input logic sel, input logic [PAR_W-1:0] row);
        return sel ? row : '0;
    endfunction

    function automatic logic [PAR_W-1:0] shift_word(input logic [PAR_W-1:0] v);
        return {v[PAR_W-WORD_W-1:0], {WORD_W{1'b0}}};
    endfunction

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // A start-of-frame word folds against an empty remainder, discarding any partial frame.
    assign rb       = in_sof ? '0 : r;
    assign f_nxt    = rb[PAR_W-1 -: WORD_W] ^ in_data;
    assign acc_fin  = acc ^ fold_term(f[addr_p1], rom_rd_q);

`ifdef BCH_ZERO_SKIP_EN
    assign zero_skip = (f_nxt == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk_1x) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        rom_rd_en  = 1'b0;
        rom_rdaddr = addr;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) begin
                    if (zero_skip) begin
                        state_nxt = in_eof ? S_OUT : S_IDLE;
                    end else begin
                        state_nxt = S_FOLD;
                    end
                end
            end
            S_FOLD: begin
                rom_rd_en = 1'b1;
                if (addr == LAST_ADDR) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = eof_flag ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = r[PAR_W-1 -: WORD_W];
                out_last  = (cnt == LAST_CNT);
                if (out_fire && (cnt == LAST_CNT)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p1: ROM data returns one cycle after the address, tagged with that address.
    always_ff @(posedge clk_1x) begin
        if (!rst_n) begin
            r        <= '0;
            acc      <= '0;
            f        <= '0;
            cnt      <= '0;
            addr     <= '0;
            addr_p1  <= '0;
            vld_p1   <= 1'b0;
            eof_flag <= 1'b0;
        end else begin
            vld_p1  <= rom_rd_en;
            addr_p1 <= rom_rdaddr;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        f        <= f_nxt;
                        acc      <= '0;
                        eof_flag <= in_eof;
                        addr     <= '0;
                        r        <= zero_skip ? shift_word(rb) : rb;
                    end
                end
                S_FOLD: begin
                    addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                    if (vld_p1) begin
                        acc <= acc_fin;
                    end
                end
                S_DRAIN: begin
                    acc <= acc_fin;
                    r   <= shift_word(r) ^ acc_fin;
                end
                S_OUT: begin
                    if (out_fire) begin
                        r   <= (cnt == LAST_CNT) ? '0 : shift_word(r);
                        cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
